// File: rtl/burst_read_seq_pkg.sv
// Shared types and helpers for the burst read sequencer and its counters.
package burst_read_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Increment modulo depth; depth need not be a power of two.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr + 32'd1 == depth) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/burst_read_seq_counter.sv
// mod_counter: loadable modulo-MOD up-counter, shared by the read address path and FIFO pointers.
module mod_counter
    import burst_read_seq_pkg::*;
#(
    parameter int unsigned W   = 4,
    parameter int unsigned MOD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over increment so a burst reload never skips the base address.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = W'(next_addr(32'(cnt_q), MOD));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/burst_read_seq.sv
// Read-burst sequencer: issues burst_len strobes with wrapping addresses, optional continuous repeat.
// Optional abort input is enabled by defining BURST_READ_SEQ_ABORT_EN.
module burst_read_seq
    import burst_read_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              cont,
    input  logic              stop,
    input  logic              rd_ready,
`ifdef BURST_READ_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              busy,
    output logic              done
);

    seq_state_t        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic              cont_q;
    logic              stop_q;
    logic [LEN_W-1:0]  beat_q;
    logic              done_q;
    logic              rd_en_q;
    logic              busy_q;

    logic              abort_c;
    logic              accept_c;
    logic              last_c;
    logic              stop_eff_c;
    logic              launch_c;
    logic              reload_c;
    logic              cnt_load_c;
    logic [ADDR_W-1:0] cnt_load_val_c;
    logic              cnt_inc_c;

`ifdef BURST_READ_SEQ_ABORT_EN
    assign abort_c = abort && (state_q == RUN);
`else
    assign abort_c = 1'b0;
`endif

    // An aborted beat is treated as not taken.
    assign accept_c   = rd_en_q && rd_ready && !abort_c;
    assign last_c     = (beat_q == len_q - LEN_W'(1));
    assign stop_eff_c = stop_q || stop;
    assign launch_c   = (state_q == IDLE) && start && (burst_len != '0);
    assign reload_c   = accept_c && last_c && cont_q && !stop_eff_c;

    assign cnt_load_c     = launch_c || reload_c;
    assign cnt_load_val_c = launch_c ? base_addr : base_q;
    assign cnt_inc_c      = accept_c && !last_c;

    mod_counter #(
        .W   (ADDR_W),
        .MOD (DEPTH)
    ) u_addr_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load_c),
        .load_val_i (cnt_load_val_c),
        .inc_i      (cnt_inc_c),
        .cnt_o      (rd_addr)
    );

    // Sequencer FSM with registered strobe, status and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            state_q <= RUN;
                            base_q  <= base_addr;
                            len_q   <= burst_len;
                            cont_q  <= cont;
                            stop_q  <= 1'b0;
                            beat_q  <= '0;
                            rd_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (abort_c) begin
                        state_q <= IDLE;
                        rd_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (accept_c) begin
                        if (!last_c) begin
                            beat_q <= beat_q + LEN_W'(1);
                        end else begin
                            done_q <= 1'b1;
                            beat_q <= '0;
                            if (!reload_c) begin
                                state_q <= IDLE;
                                rd_en_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign rd_en    = rd_en_q;
    assign beat_idx = beat_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_burst_read_seq.sv
// Scoreboard bench for burst_read_seq (DEPTH=10); abort cases run when BURST_READ_SEQ_ABORT_EN is defined.
module tb_burst_read_seq;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 10;
    localparam int unsigned LEN_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              cont;
    logic              stop;
    logic              rd_ready;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  beat_idx;
    logic              busy;
    logic              done;

    burst_read_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .cont      (cont),
        .stop      (stop),
        .rd_ready  (rd_ready),
`ifdef BURST_READ_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .beat_idx  (beat_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int cyc;
        int addr;
        int idx;
    } ev_t;

    ev_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  rdy_pat[512];
    int  stop_cyc   = 0;
    int  abort_cyc  = 0;
    bit  busy_start = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected events whenever the DUT shows a done pulse or an accepted beat.
    bit p_rst = 1'b1, p_en = 1'b0, p_ready = 1'b0, p_abort = 1'b0;
    int p_addr = 0, p_idx = 0;
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            chk("busy_vs_rd_en", int'(busy), int'(rd_en));
            if (!p_rst && !p_abort && p_en && !p_ready) begin
                chk("stall_rd_en", int'(rd_en), 1);
                chk("stall_addr", int'(rd_addr), p_addr);
                chk("stall_idx", int'(beat_idx), p_idx);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=done expected=none at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_order", int'(e.is_done), 1);
                end
            end
            if (rd_en && rd_ready && !abort) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=addr%0d expected=none at %0t", rd_addr, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_order", int'(e.is_done), 0);
                    chk("beat_addr", int'(rd_addr), e.addr);
                    chk("beat_idx", int'(beat_idx), e.idx);
                end
            end
        end
        p_rst   = rst;
        p_en    = rd_en;
        p_ready = rd_ready;
        p_abort = abort;
        p_addr  = int'(rd_addr);
        p_idx   = int'(beat_idx);
    end

    // Reference: beat k of any burst is at (base+k) mod DEPTH; bursts repeat until one ends with stop seen.
    task automatic run_txn(input int base, input int len, input bit cnt);
        ev_t evs[$];
        int  c_end = 0;
        int  beats = 0;
        if (len == 0) begin
            evs.push_back('{1'b1, 0, 0, 0});
        end else begin
            c_end = 499;
            for (int c = 1; c < 500; c++) begin
                if (rdy_pat[c] != 0) begin
                    evs.push_back('{1'b0, c, (base + beats % len) % DEPTH, beats % len});
                    beats++;
                    if (beats % len == 0) begin
                        evs.push_back('{1'b1, c, 0, 0});
                        if (!cnt || (stop_cyc >= 1 && stop_cyc <= c)) begin
                            c_end = c;
                            break;
                        end
                    end
                end
            end
        end
        if (len == 0 || abort_cyc > c_end) abort_cyc = 0;
        foreach (evs[i]) begin
            if (abort_cyc == 0 || evs[i].cyc < abort_cyc) sb_q.push_back(evs[i]);
        end
        if (abort_cyc != 0) c_end = abort_cyc;

        start     = 1'b1;
        base_addr = ADDR_W'(base);
        burst_len = LEN_W'(len);
        cont      = cnt;
        stop      = 1'b0;
        abort     = 1'b0;
        rd_ready  = (rdy_pat[0] != 0);
        for (int c = 1; c <= c_end + 1; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy_start && c == 1 && len != 0) begin
                start     = 1'b1;
                base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                burst_len = LEN_W'($urandom_range(1, 31));
                cont      = 1'($urandom_range(0, 1));
            end
            rd_ready = (rdy_pat[c] != 0);
            stop     = (c == stop_cyc);
            abort    = (c == abort_cyc) && (c <= c_end);
        end
        start      = 1'b0;
        stop       = 1'b0;
        abort      = 1'b0;
        stop_cyc   = 0;
        abort_cyc  = 0;
        busy_start = 1'b0;
    endtask

    task automatic ready_all();
        for (int i = 0; i < 512; i++) rdy_pat[i] = 1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0;
        cont = 1'b0; stop = 1'b0; rd_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_beat_idx", int'(beat_idx), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic burst with cycle-exact timing.
        ready_all();
        fork
            run_txn(3, 4, 1'b0);
            begin
                @(negedge clk);
                chk("basic_c0_rd_en", int'(rd_en), 0);
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    chk("basic_rd_en", int'(rd_en), 1);
                    chk("basic_addr", int'(rd_addr), 3 + k - 1);
                    chk("basic_done_low", int'(done), 0);
                end
                @(negedge clk);
                chk("basic_done", int'(done), 1);
                chk("basic_busy", int'(busy), 0);
                chk("basic_rd_en_end", int'(rd_en), 0);
            end
        join

        // Wrap at DEPTH with a two-cycle stall on the second beat.
        ready_all();
        rdy_pat[2] = 0; rdy_pat[3] = 0;
        run_txn(8, 4, 1'b0);

        // Continuous mode, stop raised during the second burst.
        ready_all();
        stop_cyc = 5;
        run_txn(0, 3, 1'b1);

        // Zero length gives only a done pulse.
        ready_all();
        run_txn(5, 0, 1'b0);

        // Start while busy must not disturb the running burst.
        ready_all();
        busy_start = 1'b1;
        run_txn(1, 5, 1'b0);

        // Reset during beat 2.
        sb_q.push_back('{1'b0, 1, 3, 0});
        sb_q.push_back('{1'b0, 2, 4, 1});
        start = 1'b1; base_addr = 4'd3; burst_len = 5'd8; cont = 1'b0; rd_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1; rd_ready = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_rd_en", int'(rd_en), 0);
        chk("midrst_rd_addr", int'(rd_addr), 0);
        chk("midrst_beat_idx", int'(beat_idx), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge clk); #1;
        ready_all();
        run_txn(6, 2, 1'b0);

`ifdef BURST_READ_SEQ_ABORT_EN
        // Abort coinciding with the accept of beat 1.
        ready_all();
        abort_cyc = 2;
        run_txn(2, 5, 1'b0);
        @(negedge clk);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(posedge clk); #1;
`endif

        // Randomized back-to-back transactions.
        for (int t = 0; t < 40; t++) begin
            int b, l;
            bit cm;
            b  = int'($urandom_range(0, DEPTH - 1));
            l  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            cm = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 512; i++) rdy_pat[i] = (i >= 150) ? 1 : int'($urandom_range(0, 3) != 0);
            stop_cyc   = cm ? int'($urandom_range(1, 40)) :
                         (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0);
            busy_start = ($urandom_range(0, 4) == 0);
`ifdef BURST_READ_SEQ_ABORT_EN
            abort_cyc  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0;
`endif
            run_txn(b, l, cm);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_read_seq.md
# burst_read_seq

Parametrised read-burst sequencer for the FIFO read side. On a start pulse it issues a run-time-programmable number of read strobes with wrapping addresses, stalls on back-pressure, and signals completion. It optionally repeats bursts continuously. It sits between the FIFO control logic and the storage array's read port, and generalises the fixed-length enable-triggered counter used so far.

## Interface
- ADDR_W, default 4: read address width.
- DEPTH, default 16: address modulus, 2..2**ADDR_W; need not be a power of two.
- LEN_W, default 5: burst length field width; maximum burst is 2**LEN_W-1 beats.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first address of burst; must be < DEPTH, captured with start.
- burst_len  in  LEN_W  beats per burst, captured with start.
- cont  in  1  continuous mode, captured with start.
- stop  in  1  leave continuous mode at the end of the current burst; sticky until IDLE.
- rd_ready  in  1  downstream accepts the current beat.
- rd_en  out  1  read strobe; a beat is valid.
- rd_addr  out  ADDR_W  address of the current beat.
- beat_idx  out  LEN_W  zero-based index of the current beat within its burst.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last beat of each burst is accepted.

## Operation
- States: IDLE, RUN. Encoding lives in the package.
- IDLE, start=1, burst_len≠0: capture base/len/cont, clear stop flag, go to RUN.
- IDLE, start=1, burst_len=0: stay IDLE, pulse done next cycle, no rd_en.
- RUN: rd_en=1. A beat is accepted when rd_en&&rd_ready.
  - On accept, not last beat: rd_addr ← (rd_addr+1==DEPTH) ? 0 : rd_addr+1; beat_idx+1.
  - On accept of the last beat (beat_idx==len-1), with cont=1 and no stop: pulse done, reload rd_addr=base and beat_idx=0, stay in RUN with no bubble cycle.
  - On accept of the last beat otherwise: pulse done and go to IDLE.
- stop in RUN sets the stop flag. Any beats already started complete. stop in IDLE is ignored.
- start while busy is ignored. Captured parameters do not change mid-burst.
- Address arithmetic is modulo DEPTH in ADDR_W bits. base_addr≥DEPTH is out of contract.

## Timing
- Reset values: rd_en=0, rd_addr=0, beat_idx=0, busy=0, done=0, state IDLE, stop flag 0.
- Latency: start at cycle N gives rd_en=1, rd_addr=base at N+1.
- When rd_ready=0, rd_en, rd_addr and beat_idx hold stable. There is no timeout.
- done is registered; it is high in the cycle after the accepting edge. In IDLE it coincides with rd_en=0 and busy=0.
- Throughput is one beat per cycle with rd_ready held high. A burst of L beats completes in L cycles.
- rst mid-burst: next cycle all outputs are at reset values, with no done pulse.
- done and a new start in the same cycle: start is honoured, because the state is already IDLE.

## Configuration
- BURST_READ_SEQ_ABORT_EN defined: adds input abort (1 bit).
  - abort in RUN: next cycle IDLE, rd_en=0, busy=0, no done pulse.
  - abort has priority over an accept in the same cycle; that beat counts as not taken.
  - abort in IDLE is ignored.
- Undefined: no abort port. Only rst or completion leaves RUN.

## Structure
- Package burst_read_seq_pkg holds:
  - typedef enum logic {IDLE, RUN} seq_state_t;
  - a function next_addr(addr, depth) implementing the modulo increment.
- Sub-module mod_counter #(W, MOD) is instantiated for rd_addr, with load, inc and wrap. It is reusable for FIFO pointers.

## Test plan
- Basic burst: DEPTH=16, base=3, len=4, rd_ready=1 → rd_addr 3,4,5,6 on cycles N+1..N+4; done at N+5; busy low at N+5.
- Wrap and stall: DEPTH=10, base=8, len=4, rd_ready low on the 2nd beat for 2 cycles → addr 8,9,9,9,0,1; beat_idx holds at 1 during the stall; a single done pulse.
- Continuous: base=0, len=3, cont=1, stop asserted during the second burst → addresses 0,1,2,0,1,2 gapless; two done pulses; then IDLE.
- Edge cases:
  - len=0 → a done pulse only, no rd_en.
  - start while busy → ignored, and the burst is unchanged.
- Reset mid-burst at beat 2 → all outputs zero the next cycle; a following start works normally.
- With BURST_READ_SEQ_ABORT_EN, abort on the same cycle as an accepted beat 1 → rd_en=0 next cycle, no done pulse.
